sadd_host: RTL and testbench



---
 rtl/sadd_host_pkg.sv | 10 +
 rtl/sadd.sv | 22 ++
 rtl/sadd_host_piso_shreg.sv | 28 ++
 rtl/sadd_host.sv | 99 +++++++++
 tb/tb_sadd_host.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/sadd_host_pkg.sv
// Shared definitions for the bit-serial adder host: FSM state encoding.
package sadd_host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sadd.sv
// Bit-serial adder: one carry flop, sum bit is combinational in carry and x/y.
module sadd (
    input  logic clk,
    input  logic rst_b,
    input  logic x,
    input  logic y,
    output logic z
);

    logic carry_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= (x & y) | (x & carry_reg) | (y & carry_reg);
        end
    end

    assign z = x ^ y ^ carry_reg;

endmodule

// File: rtl/sadd_host_piso_shreg.sv
// Parallel-in/serial-out shift register: load W bits, shift right with zero
// fill, serial output is the current LSB.
module piso_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= din;
        end else if (shift) begin
            q_reg <= q_reg >> 1;
        end
    end

    assign sout = q_reg[0];

endmodule

// File: rtl/sadd_host.sv
// Host for the serial adder: takes parallel operands, streams them LSB-first
// for W+1 cycles and collects the returned z bits into a W+1 bit sum.
module sadd_host
    import sadd_host_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         x,
    output logic         y,
    input  logic         z,
    output logic [W:0]   sum,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CW = (W + 1 > 1) ? $clog2(W + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(W);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [W:0]      sum_reg;
    logic            load, shift;
    logic [1:0][W-1:0] op_din;
    logic [1:0]      op_sout;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // z is sampled on the same edge that advances the adder carry, so the
    // collector and the adder stay in lockstep across the frame.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                cnt_reg <= '0;
                sum_reg <= '0;
            end else if (shift) begin
                cnt_reg <= cnt_reg + 1'b1;
                sum_reg <= {z, sum_reg[W:1]};
            end
        end
    end

    assign op_din[0] = a;
    assign op_din[1] = b;

    // The W-bit operand registers drain to zero after W shifts, so the extra
    // frame cycle and all of DONE/IDLE drive x=y=0.
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
        piso_shreg #(.W(W)) u_shreg (
            .clk   (clk),
            .rst_b (rst_b),
            .load  (load),
            .shift (shift),
            .din   (op_din[gi]),
            .sout  (op_sout[gi])
        );
    end

    assign x         = op_sout[0];
    assign y         = op_sout[1];
    assign sum       = sum_reg;
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

endmodule

// File: tb/tb_sadd_host.sv
// Directed bench: sadd_host wired to sadd, table-driven transactions plus
// hand-written reset sequences.
module tb_sadd_host;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         x, y, z;
    logic [W:0]   sum;
    logic         out_valid;
    logic         out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sadd_host #(.W(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .x         (x),
        .y         (y),
        .z         (z),
        .sum       (sum),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    sadd u_adder (
        .clk   (clk),
        .rst_b (rst_b),
        .x     (x),
        .y     (y),
        .z     (z)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
        int           hold;
        bit           pulse;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the result is taken.
    task automatic run_txn(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W:0] exp, input int hold, input bit pulse,
                           input string tag);
        logic [W:0] first_sum;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid = 1'b0;
                a = '0;
                b = '0;
            end
            if (pulse && i == 1) begin
                in_valid = 1'b1;
                a = 4'd1;
                b = 4'd1;
            end
            check($sformatf("%s x[%0d]", tag, i), 32'(x), (i < W) ? 32'(va[i]) : 32'd0);
            check($sformatf("%s y[%0d]", tag, i), 32'(y), (i < W) ? 32'(vb[i]) : 32'd0);
            check($sformatf("%s z[%0d]", tag, i), 32'(z), 32'(exp[i]));
            check($sformatf("%s busy out_valid[%0d]", tag, i), 32'(out_valid), 32'd0);
            check($sformatf("%s busy in_ready[%0d]", tag, i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check({tag, " out_valid latency"}, 32'(out_valid), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(exp));
        check({tag, " done in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " done x"}, 32'(x), 32'd0);
        check({tag, " done y"}, 32'(y), 32'd0);
        first_sum = sum;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("%s hold out_valid[%0d]", tag, h), 32'(out_valid), 32'd1);
            check($sformatf("%s hold sum[%0d]", tag, h), 32'(sum), 32'(exp));
            check($sformatf("%s hold in_ready[%0d]", tag, h), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " released out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " released in_ready"}, 32'(in_ready), 32'd1);
        $display("[TB] txn %s: %0d + %0d -> sum %0d (expected %0d)", tag, va, vb, first_sum, exp);
    endtask

    initial begin
        vecs[0] = '{a: 4'd3,  b: 4'd5,  exp: 5'd8,  hold: 0, pulse: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp: 5'd30, hold: 0, pulse: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  exp: 5'd0,  hold: 0, pulse: 1'b0};
        vecs[3] = '{a: 4'd9,  b: 4'd6,  exp: 5'd15, hold: 3, pulse: 1'b1};
        vecs[4] = '{a: 4'd7,  b: 4'd1,  exp: 5'd8,  hold: 0, pulse: 1'b0};
        vecs[5] = '{a: 4'd2,  b: 4'd2,  exp: 5'd4,  hold: 0, pulse: 1'b0};

        rst_b = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #2;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset x", 32'(x), 32'd0);
        check("reset y", 32'(y), 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].hold, vecs[v].pulse,
                    $sformatf("vec%0d", v));
        end

        // Reset two bits into a 15+1 frame: carry is set in the adder here.
        a = 4'd15;
        b = 4'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("midshift rst out_valid", 32'(out_valid), 32'd0);
        check("midshift rst sum", 32'(sum), 32'd0);
        check("midshift rst x", 32'(x), 32'd0);
        check("midshift rst y", 32'(y), 32'd0);
        check("midshift rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        run_txn(4'd1, 4'd1, 5'd2, 0, 1'b0, "after_rst");

        // Reset while a nonzero result is presented.
        a = 4'd3;
        b = 4'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (W + 1) @(negedge clk);
        check("done pre-rst out_valid", 32'(out_valid), 32'd1);
        check("done pre-rst sum", 32'(sum), 32'd8);
        rst_b = 1'b0;
        #1;
        check("done rst out_valid", 32'(out_valid), 32'd0);
        check("done rst sum", 32'(sum), 32'd0);
        check("done rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
